// File: rtl/serial_adder_ctrl_if.sv
// Request-side bundle for the bit-serial add/subtract sequencer.
// The requesting datapath holds the master modport; the sequencer holds the slave modport.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    // Handshake: a request is taken on a rising edge where start=1 and ready=1.
    // Otherwise start is ignored. done pulses for one cycle when Sum/Cout/Ovf become valid.
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, sub, A_in, B_in,
        input  ready, busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, sub, A_in, B_in,
        output ready, busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external 1-bit full-adder slice, LSB first.
// Subtraction is A + ~B + 1, with the +1 supplied as the initial carry-in.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_adder_ctrl_if.slave     req,
    output logic                   fa_a,
    output logic                   fa_b,
    output logic                   fa_cin,
    input  logic                   fa_sum,
    input  logic                   fa_cout,
    output logic [1:0]             state_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req.start) begin
                        a_sh_q  <= req.A_in;
                        b_sh_q  <= req.sub ? ~req.B_in : req.B_in;
                        c_q     <= req.sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q  <= {fa_sum, sum_q[WIDTH-1:1]};
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    c_q    <= fa_cout;
                    // c_q still holds the carry into the MSB on the last bit.
                    if (cnt_q == LAST) begin
                        cout_q  <= fa_cout;
                        ovf_q   <= c_q ^ fa_cout;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // busy_q is high exactly in RUN, so it gates the slice inputs to zero elsewhere.
    assign fa_a    = busy_q & a_sh_q[0];
    assign fa_b    = busy_q & b_sh_q[0];
    assign fa_cin  = busy_q & c_q;

    assign req.ready = ready_q;
    assign req.busy  = busy_q;
    assign req.done  = done_q;
    assign req.Sum   = sum_q;
    assign req.Cout  = cout_q;
    assign req.Ovf   = ovf_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a mux-based full-adder slice in the loop.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic [1:0] state_o;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.slave),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout),
    .state_o (state_o)
  );

  // external slice: mux-based full adder
  logic fa_p;
  assign fa_p    = fa_a ^ fa_b;
  assign fa_sum  = fa_cin ? ~fa_p : fa_p;
  assign fa_cout = fa_p ? fa_cin : fa_a;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;
  endtask

  // Issue one operation and follow it to completion. inject_at >= 0 pulses start
  // with junk operands in that RUN cycle.
  task automatic run_op(input vec_t v, input int inject_at);
    int n;
    int busy_cnt;
    int done_cnt;
    logic [W+1:0] e;
    @(negedge clk);
    check("ready_before_start", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    bus.sub   = v.s;
    bus.A_in  = v.a;
    bus.B_in  = v.b;
    exp_q.push_back({v.cout, v.ovf, v.sum});
    @(negedge clk);
    drive_idle();
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.ready) begin
        n_cmp++; n_err++;
        $display("FAIL ready_in_run: got 1 expected 0 at cycle %0d", n);
      end
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.sub   = ~v.s;
        bus.A_in  = ~v.a;
        bus.B_in  = v.a;
      end else begin
        drive_idle();
      end
      @(negedge clk);
      n++;
    end
    drive_idle();
    check("done_latency", n, W);
    check("busy_cycles", busy_cnt, W);
    check("done_with_ready", {31'd0, bus.done & bus.ready}, 32'd0);
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: got done expected none");
    end else begin
      e = exp_q.pop_front();
      check("sum", {24'd0, bus.Sum}, {24'd0, e[W-1:0]});
      check("cout", {31'd0, bus.Cout}, {31'd0, e[W+1]});
      check("ovf", {31'd0, bus.Ovf}, {31'd0, e[W]});
    end
    done_cnt = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("single_done", done_cnt, 1);
    check("idle_ready", {31'd0, bus.ready}, 32'd1);
    check("sum_held", {24'd0, bus.Sum}, {24'd0, v.sum});
  endtask

  initial begin
    int rdy_cnt;
    int busy_cnt;
    int done_cnt;
    int rdy_t[$];
    vec_t v;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, s: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h80, s: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h20, s: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, s: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h01, b: 8'h01, s: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 8'h20, b: 8'h10, s: 1'b1, sum: 8'h10, cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h7F, b: 8'h01, s: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[8] = '{a: 8'h00, b: 8'h00, s: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[9] = '{a: 8'hA5, b: 8'h0F, s: 1'b0, sum: 8'hB4, cout: 1'b0, ovf: 1'b0};

    drive_idle();
    rst_n = 1'b0;
    #12;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sum", {24'd0, bus.Sum}, 32'd0);
    check("rst_cout_ovf", {30'd0, bus.Cout, bus.Ovf}, 32'd0);
    check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], -1);

    // start pulsed in RUN cycle 3 must not disturb the running operation
    run_op(vecs[0], 3);

    // async reset mid-RUN aborts without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.A_in = 8'h5A; bus.B_in = 8'h3C;
    @(negedge clk);
    drive_idle();
    repeat (4) @(negedge clk);
    check("busy_before_abort", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_sum", {24'd0, bus.Sum}, 32'd0);
    check("abort_cout_ovf", {30'd0, bus.Cout, bus.Ovf}, 32'd0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    v = '{a: 8'h01, b: 8'h01, s: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0};
    run_op(v, -1);

    // start held high: one accept every W+2 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.A_in = 8'h01; bus.B_in = 8'h02;
    rdy_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < 3 * (W + 2); t++) begin
      if (bus.ready) begin
        rdy_cnt++;
        rdy_t.push_back(t);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.done && bus.ready) begin
        n_cmp++; n_err++;
        $display("FAIL b2b_done_with_ready: got 1 expected 0 at t=%0d", t);
      end
      @(negedge clk);
    end
    drive_idle();
    check("b2b_accepts", rdy_cnt, 3);
    for (int i = 0; i < rdy_t.size(); i++) check("b2b_accept_time", rdy_t[i], i * (W + 2));
    check("b2b_busy", busy_cnt, 3 * W);
    check("b2b_done", done_cnt, 3);
    check("b2b_sum", {24'd0, bus.Sum}, 32'h03);
    check("b2b_ready_after", {31'd0, bus.ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
